imem_program_loader: RTL and testbench

Sequential instruction encoder/writer feeding the single-cycle MIPS core's instruction memory. Accepts decoded instruction descriptions (instruction class plus register/immediate fields) over a valid/ready handshake. Packs each into a 32-bit MIPS word and writes it to consecutive instruction-memory addresses. Together with the core's opcode-to-control decode, it forms the two ends of the instruction-word format. The bench and boot logic use it to load programs.

---
 rtl/imem_program_loader.sv | 141 ++++++++++++++
 tb/tb_imem_program_loader.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_program_loader.sv
// Encodes decoded MIPS instruction descriptions into 32-bit words and writes them to
// consecutive instruction-memory addresses. Optional feature macro: LOADER_CHECKSUM_EN.
module imem_program_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVE,
        S_DRAIN,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [ADDR_W+1:0] LP_MAX       = (ADDR_W+2)'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] LP_BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   LP_ONE       = (ADDR_W+1)'(1);
    localparam logic [2:0]        LP_KIND_RSVD = 3'd7;

    state_t            r_state;
    logic              r_fresh;
    logic [ADDR_W+1:0] w_used;
    logic              w_accept;
    logic              w_bad;
    logic [31:0]       w_enc;

    // A beat registered last cycle is still in flight, so it counts against capacity.
    assign w_used   = {1'b0, word_count} + (ADDR_W+2)'(imem_we);
    assign in_ready = (r_state == S_ACTIVE) && !r_fresh && (w_used < LP_MAX);
    assign w_accept = in_valid && in_ready;
    assign w_bad    = w_accept && (in_kind == LP_KIND_RSVD);

    always_comb begin
        w_enc = '0;
        case (in_kind)
            3'd0:    w_enc = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
            3'd1:    w_enc = {6'b100011, in_rs, in_rt, in_imm};
            3'd2:    w_enc = {6'b101011, in_rs, in_rt, in_imm};
            3'd3:    w_enc = {6'b000101, in_rs, in_rt, in_imm};
            3'd4:    w_enc = {6'b000010, in_target};
            3'd5:    w_enc = {6'b001000, in_rs, in_rt, in_imm};
            3'd6:    w_enc = {6'b000100, in_rs, in_rt, in_imm};
            default: w_enc = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_fresh    <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
        end else begin
            imem_we <= 1'b0;
            r_fresh <= 1'b0;
            if (imem_we) begin
                word_count <= word_count + LP_ONE;
            end
            if (start) begin
                r_state    <= S_ACTIVE;
                r_fresh    <= 1'b1;
                word_count <= '0;
                busy       <= 1'b1;
                done       <= 1'b0;
                err        <= 1'b0;
            end else begin
                case (r_state)
                    S_ACTIVE: begin
                        if (w_bad) begin
                            r_state <= S_ERROR;
                            err     <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            // Address accounts for the word being written this cycle.
                            if (w_accept) begin
                                imem_we    <= 1'b1;
                                imem_wdata <= w_enc;
                                imem_addr  <= LP_BASE + w_used[ADDR_W-1:0];
                            end
                            if (finish) begin
                                r_state <= S_DRAIN;
                            end
                        end
                    end
                    S_DRAIN: begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            checksum <= '0;
        end else if (start) begin
            checksum <= '0;
        end else if (imem_we) begin
            checksum <= checksum ^ imem_wdata;
        end
    end
`endif

endmodule

// File: tb/tb_imem_program_loader.sv
// Bench for imem_program_loader: two instances (default and small wrapping capacity)
// driven in lockstep and compared each cycle against a transaction-level model.
module tb_imem_program_loader;

    localparam int unsigned AW = 8;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic        start, finish, in_valid;
    logic [2:0]  in_kind;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;
    logic [25:0] in_target;

    logic          rdy[2], we[2], busy[2], done[2], err[2];
    logic [AW-1:0] addr[2];
    logic [31:0]   wdata[2];
    logic [AW:0]   wc[2];
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]   cks[2];
`endif

    imem_program_loader #(.ADDR_W(AW), .BASE_ADDR(0), .MAX_WORDS(256)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(rdy[0]), .in_kind(in_kind),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
        .imem_we(we[0]), .imem_addr(addr[0]), .imem_wdata(wdata[0]),
        .busy(busy[0]), .done(done[0]), .err(err[0]), .word_count(wc[0])
`ifdef LOADER_CHECKSUM_EN
        , .checksum(cks[0])
`endif
    );

    imem_program_loader #(.ADDR_W(AW), .BASE_ADDR(254), .MAX_WORDS(4)) u_cap (
        .clk(clk), .reset_n(reset_n), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(rdy[1]), .in_kind(in_kind),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
        .imem_we(we[1]), .imem_addr(addr[1]), .imem_wdata(wdata[1]),
        .busy(busy[1]), .done(done[1]), .err(err[1]), .word_count(wc[1])
`ifdef LOADER_CHECKSUM_EN
        , .checksum(cks[1])
`endif
    );

    typedef struct {
        logic [2:0]  kind;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[7];

    int n_checks = 0;
    int n_fail   = 0;

    int unsigned P_BASE[2] = '{0, 254};
    int unsigned P_MAX[2]  = '{256, 4};

    // Session-level model: accepted-beat count, one-deep write pipeline, flags.
    bit          m_act[2], m_wv[2], m_err[2], m_done[2], m_busy[2], m_close[2];
    int          m_age[2], m_acc[2], m_cnt[2];
    logic [31:0] m_wd[2], m_cks[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                                       input logic [15:0] imm, input logic [25:0] tgt);
        logic [5:0] op;
        case (k)
            3'd0:    return {6'd0, rs, rt, rd, sh, fn};
            3'd4:    return {6'h02, tgt};
            3'd1:    op = 6'h23;
            3'd2:    op = 6'h2B;
            3'd3:    op = 6'h05;
            3'd5:    op = 6'h08;
            3'd6:    op = 6'h04;
            default: return 32'd0;
        endcase
        return {op, rs, rt, imm};
    endfunction

    function automatic bit exp_ready(input int k);
        return m_act[k] && (m_age[k] >= 1) && (m_acc[k] < int'(P_MAX[k]));
    endfunction

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 0; m_wv[k] = 0; m_err[k] = 0; m_done[k] = 0; m_busy[k] = 0; m_close[k] = 0;
            m_age[k] = 0; m_acc[k] = 0; m_cnt[k] = 0; m_wd[k] = '0; m_cks[k] = '0;
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("ready%0d", k), 32'(rdy[k]), 32'(exp_ready(k)));
            chk($sformatf("we%0d", k), 32'(we[k]), 32'(m_wv[k]));
            chk($sformatf("count%0d", k), 32'(wc[k]), m_cnt[k]);
            chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(m_busy[k]));
            chk($sformatf("done%0d", k), 32'(done[k]), 32'(m_done[k]));
            chk($sformatf("err%0d", k), 32'(err[k]), 32'(m_err[k]));
            if (m_wv[k]) begin
                chk($sformatf("addr%0d", k), 32'(addr[k]), (P_BASE[k] + m_cnt[k]) % 256);
                chk($sformatf("wdata%0d", k), wdata[k], m_wd[k]);
            end
`ifdef LOADER_CHECKSUM_EN
            chk($sformatf("checksum%0d", k), cks[k], m_cks[k]);
`endif
        end
    endtask

    task automatic mstep();
        for (int k = 0; k < 2; k++) begin
            bit acc;
            acc = exp_ready(k) && in_valid;
            if (m_wv[k]) begin
                m_cks[k] ^= m_wd[k];
                m_cnt[k]++;
            end
            if (start) begin
                m_act[k] = 1; m_age[k] = 0; m_acc[k] = 0; m_cnt[k] = 0; m_err[k] = 0;
                m_done[k] = 0; m_busy[k] = 1; m_wv[k] = 0; m_close[k] = 0; m_cks[k] = '0;
            end else begin
                m_wv[k] = 0;
                if (m_close[k]) begin
                    m_close[k] = 0; m_done[k] = 1; m_busy[k] = 0;
                end
                if (acc && in_kind == 3'd7) begin
                    m_err[k] = 1; m_act[k] = 0; m_busy[k] = 0;
                end else begin
                    if (acc) begin
                        m_wv[k] = 1;
                        m_wd[k] = enc(in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target);
                        m_acc[k]++;
                    end
                    if (m_act[k] && finish) begin
                        m_act[k] = 0; m_close[k] = 1;
                    end
                end
                if (m_age[k] < 1000) m_age[k]++;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        mstep();
        @(posedge clk);
        #1;
        start    = 1'b0;
        finish   = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic set_beat(input vec_t v);
        in_valid = 1'b1; in_kind = v.kind; in_rs = v.rs; in_rt = v.rt; in_rd = v.rd;
        in_shamt = v.sh; in_funct = v.fn; in_imm = v.imm; in_target = v.tgt;
    endtask

    task automatic check_zero(input string nm);
        for (int k = 0; k < 2; k++) begin
            chk({nm, "_ready"}, 32'(rdy[k]), 32'd0);
            chk({nm, "_we"}, 32'(we[k]), 32'd0);
            chk({nm, "_addr"}, 32'(addr[k]), 32'd0);
            chk({nm, "_wdata"}, wdata[k], 32'd0);
            chk({nm, "_busy"}, 32'(busy[k]), 32'd0);
            chk({nm, "_done"}, 32'(done[k]), 32'd0);
            chk({nm, "_err"}, 32'(err[k]), 32'd0);
            chk({nm, "_count"}, 32'(wc[k]), 32'd0);
`ifdef LOADER_CHECKSUM_EN
            chk({nm, "_checksum"}, cks[k], 32'd0);
`endif
        end
    endtask

    task automatic open_session();
        start = 1'b1;
        tick();
        chk("ready_after_start", 32'(rdy[0]), 32'd0);
        tick();
    endtask

    initial begin
        vec_t v;
        int   nw;
        tbl[0] = '{3'd1, 5'd29, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0004, 26'd0,     32'h8FA80004};
        tbl[1] = '{3'd0, 5'd1,  5'd2, 5'd3, 5'd0, 6'h20, 16'h0000, 26'd0,     32'h00221820};
        tbl[2] = '{3'd4, 5'd0,  5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h10,    32'h08000010};
        tbl[3] = '{3'd6, 5'd1,  5'd2, 5'd0, 5'd0, 6'h00, 16'hFFFF, 26'd0,     32'h1022FFFF};
        tbl[4] = '{3'd2, 5'd29, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0004, 26'd0,     32'hAFA80004};
        tbl[5] = '{3'd3, 5'd1,  5'd2, 5'd0, 5'd0, 6'h00, 16'h0003, 26'd0,     32'h14220003};
        tbl[6] = '{3'd5, 5'd0,  5'd9, 5'd0, 5'd0, 6'h00, 16'h1234, 26'd0,     32'h20091234};

        reset_n = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
        in_funct = '0; in_imm = '0; in_target = '0;
        mreset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("por");
        reset_n = 1'b1;
        tick();

        // Encoding table, one beat per session.
        for (int i = 0; i < 7; i++) begin
            open_session();
            set_beat(tbl[i]);
            tick();
            chk("tbl_we", 32'(we[0]), 32'd1);
            chk("tbl_wdata", wdata[0], tbl[i].exp);
        end

        // Back-to-back beats on consecutive cycles, then clean close.
        open_session();
        for (int i = 1; i < 4; i++) begin
            set_beat(tbl[i]);
            tick();
            chk("b2b_we", 32'(we[0]), 32'd1);
            chk("b2b_addr", 32'(addr[0]), 32'(i - 1));
            chk("b2b_wdata", wdata[0], tbl[i].exp);
        end
        finish = 1'b1;
        tick();
        tick();
        chk("b2b_done", 32'(done[0]), 32'd1);
        chk("b2b_busy", 32'(busy[0]), 32'd0);
        chk("b2b_count", 32'(wc[0]), 32'd3);

        // Reserved kind after two good beats.
        open_session();
        set_beat(tbl[0]); tick();
        set_beat(tbl[4]); tick();
        v = tbl[0]; v.kind = 3'd7;
        set_beat(v); tick();
        chk("rsvd_err", 32'(err[0]), 32'd1);
        chk("rsvd_ready", 32'(rdy[0]), 32'd0);
        chk("rsvd_count", 32'(wc[0]), 32'd2);
        chk("rsvd_we", 32'(we[0]), 32'd0);
        set_beat(tbl[1]); tick();
        chk("rsvd_nowrite", 32'(we[0]), 32'd0);
        start = 1'b1; tick();
        chk("rsvd_cleared", 32'(err[0]), 32'd0);
        tick();

        // Capacity of the small instance, with address wrap from 254.
        open_session();
        nw = 0;
        for (int i = 0; i < 6; i++) begin
            v = tbl[i];
            set_beat(v);
            tick();
            nw += int'(we[1]);
        end
        tick(); nw += int'(we[1]);
        chk("cap_writes", 32'(nw), 32'd4);
        chk("cap_ready", 32'(rdy[1]), 32'd0);
        chk("cap_busy", 32'(busy[1]), 32'd1);
        finish = 1'b1; tick(); tick();
        chk("cap_done", 32'(done[1]), 32'd1);

        // Beat and finish in the same cycle.
        open_session();
        set_beat(tbl[6]); finish = 1'b1; tick();
        chk("bf_we", 32'(we[0]), 32'd1);
        chk("bf_done_early", 32'(done[0]), 32'd0);
        tick();
        chk("bf_done", 32'(done[0]), 32'd1);

`ifdef LOADER_CHECKSUM_EN
        open_session();
        set_beat(tbl[0]); tick();
        set_beat(tbl[1]); tick();
        tick();
        chk("checksum_pair", cks[0], 32'h8F8A1824);
`endif

        // Asynchronous reset mid-stream drops the pending write.
        open_session();
        set_beat(tbl[2]); tick();
        set_beat(tbl[3]);
        #2 reset_n = 1'b0;
        #1 check_zero("midrst");
        in_valid = 1'b0;
        mreset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        tick();

        // Randomized traffic against the model.
        start = 1'b1;
        tick();
        for (int c = 0; c < 500; c++) begin
            start    = ($urandom % 40) == 0;
            finish   = ($urandom % 30) == 0;
            in_valid = ($urandom % 10) < 7;
            in_kind  = (($urandom % 25) == 0) ? 3'd7 : 3'($urandom % 7);
            in_rs = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
            in_shamt = 5'($urandom); in_funct = 6'($urandom);
            in_imm = 16'($urandom); in_target = 26'($urandom);
            tick();
        end
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
